spectrum_bar_draw: RTL
======================

SPECTRUM_BAR_DRAW -- requirements
Module: spectrum_bar_draw

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset, with the clock port named lcd_clk and the reset port named rst.
REQ-002 Parameters SHALL be, one per line:
- H_DISP, 1024, active width in pixels.
- V_DISP, 768, active height in lines.
- BAR_SHIFT, 3, log2 of bar width in pixels; 128 bars.
- MAG_SHIFT, 2, right-shift from magnitude to bar height.
- RD_LAT, 3, cycles from data_req to fifo_rd_data valid.
- BAR_COLOR, 24'h00FF00, bar RGB.
- BG_COLOR, 24'h000000, background RGB.
REQ-003 Ports SHALL be, one per line:
- lcd_clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- lcd_vs  in  1  vertical sync, active-high.
- fifo_rd_empty  in  1  spectrum FIFO empty.
- fifo_rd_data  in  32  FFT bin; [31:16] real, [15:0] imag, signed.
- data_req  out  1  one-cycle request for the next bin.
- wr_over  out  1  one-cycle pulse: the bin is consumed.
- pixel_xpos  in  11  current active column.
- pixel_ypos  in  11  current active row.
- pixel_data  out  24  RGB output.
- fetch_busy  out  1  high while a fetch sequence runs.

Function
REQ-004 A fetch sequence SHALL start on the rising edge of lcd_vs (registered lcd_vs low, input high) when the FSM is in IDLE. A rising edge seen in any other state SHALL be ignored.
REQ-005 The FSM states SHALL be IDLE, REQ, WAIT, CALC, STORE and NEXT; fetch_busy SHALL be high in every state except IDLE.
REQ-006 REQ behaviour:
- While fifo_rd_empty=1, remain in REQ with data_req=0.
- Otherwise pulse data_req for exactly 1 cycle and go to WAIT.
REQ-007 WAIT SHALL count RD_LAT cycles, then go to CALC; CALC SHALL capture fifo_rd_data.
REQ-008 Magnitude computation:
- Take |re| and |im|, saturating -32768 to 32767.
- mag = max + (min>>1), 17 bits unsigned.
- h = mag>>MAG_SHIFT, saturated to V_DISP.
REQ-009 STORE SHALL write h into height[idx] and pulse wr_over for exactly 1 cycle.
REQ-010 NEXT SHALL go to IDLE if idx=127 (clearing idx to 0); otherwise it SHALL increment idx and go to REQ. Consecutive data_req pulses are therefore at least RD_LAT+4 cycles apart.
REQ-011 Pixel colour rules:
- bar = pixel_xpos>>BAR_SHIFT.
- Output BAR_COLOR when xpos<(128<<BAR_SHIFT), the low BAR_SHIFT bits of xpos are not all ones (1-pixel gap), and pixel_ypos>=V_DISP-height[bar].
- Output BG_COLOR otherwise, including when xpos>=H_DISP or ypos>=V_DISP.
REQ-012 pixel_data SHALL be registered with a latency of exactly 2 cycles from pixel_xpos/pixel_ypos.
REQ-013 height[] SHALL only be updated in STORE; a bin whose fetch is still pending SHALL display its previous value.
REQ-014 A bin with h=0 SHALL draw no pixels; a bin with h=V_DISP SHALL fill the whole column.

Reset
REQ-015 With rst=1 at a clock edge, the following SHALL hold on the next cycle:
- FSM in IDLE, idx=0.
- data_req=0, wr_over=0, fetch_busy=0.
- pixel_data=24'h0.
- All height[] entries =0.
REQ-016 A reset asserted mid-fetch SHALL abort the fetch without issuing any further data_req or wr_over pulses.

Configuration
REQ-017 Macro SPECTRUM_PEAK_HOLD_EN SHALL control the peak-hold feature.
- Defined: per-bin peak[] registers (reset 0). In STORE, peak[idx]=max(peak[idx],h); otherwise, at each fetch start, peak[idx] decrements by 1 if nonzero. Rows V_DISP-peak and V_DISP-peak+1 of the bar (gap column excluded, peak>0) output 24'hFFFFFF, taking priority over BAR_COLOR.
- Undefined: no peak registers exist and the output is exactly as REQ-011.

Verification
REQ-018 Reset handling: rst pulsed during WAIT at idx=5 -> next cycle IDLE, fetch_busy=0, no further data_req or wr_over.
REQ-019 Full fetch: lcd_vs rising edge, FIFO holding 128 words -> exactly 128 data_req and 128 wr_over pulses; data_req spacing >=7 cycles at RD_LAT=3; fetch_busy falls after the 128th wr_over.
REQ-020 Magnitude: bin 2 = re 0x0400, im 0xFE00 -> mag 1280, h 320; pixels (x=16..22, y>=448) = BAR_COLOR; (x=16, y=447) and (x=23, y=700) = BG_COLOR; 2-cycle latency checked.
REQ-021 Saturation: re 0x8000, im 0x8000 -> mag 49150, h saturated to 768 -> the whole column is BAR_COLOR.
REQ-022 Empty stall and retrigger: fifo_rd_empty held high for 50 cycles at idx=10 -> no data_req while empty, resume when it drops; a second lcd_vs edge mid-fetch -> ignored, total pulse count still 128.
REQ-023 Peak hold (macro defined): bin 0 gets h=100, then h=0 over the next frames -> marker at rows 668/669, moving down by 1 row per frame.

Source files
------------

// File: rtl/spectrum_bar_draw.sv
// Spectrum bar renderer: fetches 128 FFT bins from a FIFO on each vsync and draws them as bars.
// Define SPECTRUM_PEAK_HOLD_EN to add decaying white peak markers above each bar.
module spectrum_bar_draw #(
  parameter int          H_DISP    = 1024,
  parameter int          V_DISP    = 768,
  parameter int          BAR_SHIFT = 3,
  parameter int          MAG_SHIFT = 2,
  parameter int          RD_LAT    = 3,
  parameter logic [23:0] BAR_COLOR = 24'h00FF00,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic        lcd_clk,
  input  logic        rst,
  input  logic        lcd_vs,
  input  logic        fifo_rd_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        data_req,
  output logic        wr_over,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [23:0] pixel_data,
  output logic        fetch_busy
);

  localparam int NUM_BARS = 128;
  localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [10:0]      V_LIM     = 11'(V_DISP);
  localparam logic [10:0]      H_LIM     = 11'(H_DISP);
  localparam logic [10:0]      BAR_LIM   = 11'(NUM_BARS << BAR_SHIFT);
  localparam logic [10:0]      GAP_MASK  = 11'((1 << BAR_SHIFT) - 1);
  localparam logic [16:0]      H_SAT     = 17'(V_DISP);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CALC, STORE, NEXT} state_t;

  state_t           state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      sample_q, sample_d;
  logic             data_req_q, data_req_d;
  logic             wr_over_q, wr_over_d;
  logic             fetch_busy_q, fetch_busy_d;
  logic             vs_q, vs_d;
  logic [10:0]      height_q [NUM_BARS];
  logic [10:0]      height_d [NUM_BARS];

  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_bar_q, s1_bar_d;
  logic [10:0]      s1_y_q, s1_y_d;
  logic [23:0]      pixel_data_q, pixel_data_d;

  logic             fetch_start;
  logic [15:0]      abs_re, abs_im, mag_max, mag_min;
  logic [16:0]      mag, h_full;
  logic [10:0]      h_new;
  logic [10:0]      bar_top;
  logic             bar_on;
  logic             peak_mark;

  // -32768 has no positive counterpart in 16 bits, so it saturates to 32767
  function automatic logic [15:0] abs_sat(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    else if (v[15])    return ~v + 16'd1;
    else               return v;
  endfunction

  // alpha-max-plus-beta-min magnitude estimate, clipped to the screen height
  always_comb begin
    abs_re  = abs_sat(sample_q[31:16]);
    abs_im  = abs_sat(sample_q[15:0]);
    mag_max = (abs_re >= abs_im) ? abs_re : abs_im;
    mag_min = (abs_re >= abs_im) ? abs_im : abs_re;
    mag     = 17'(mag_max) + 17'(mag_min >> 1);
    h_full  = mag >> MAG_SHIFT;
    h_new   = (h_full > H_SAT) ? V_LIM : h_full[10:0];
  end

  assign fetch_start = (state_q == IDLE) && lcd_vs && !vs_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    sample_d   = sample_q;
    data_req_d = 1'b0;
    wr_over_d  = 1'b0;
    vs_d       = lcd_vs;
    height_d   = height_q;
    case (state_q)
      IDLE: if (fetch_start) state_d = REQ;
      REQ: begin
        if (!fifo_rd_empty) begin
          data_req_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = CALC;
        else                         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      CALC: begin
        sample_d = fifo_rd_data;
        state_d  = STORE;
      end
      STORE: begin
        height_d[idx_q] = h_new;
        wr_over_d       = 1'b1;
        state_d         = NEXT;
      end
      NEXT: begin
        if (idx_q == 7'd127) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 7'd1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    fetch_busy_d = (state_d != IDLE);
  end

  // Stage 1 decodes the column; stage 2 compares against the stored bar height
  always_comb begin
    s1_valid_d = (pixel_xpos < BAR_LIM) && (pixel_xpos < H_LIM) && (pixel_ypos < V_LIM) &&
                 ((pixel_xpos & GAP_MASK) != GAP_MASK);
    s1_bar_d   = 7'(pixel_xpos >> BAR_SHIFT);
    s1_y_d     = pixel_ypos;
    bar_top    = V_LIM - height_q[s1_bar_q];
    bar_on     = s1_valid_q && (s1_y_q >= bar_top);
    if (peak_mark)   pixel_data_d = 24'hFFFFFF;
    else if (bar_on) pixel_data_d = BAR_COLOR;
    else             pixel_data_d = BG_COLOR;
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [10:0] peak_q [NUM_BARS];
  logic [10:0] peak_d [NUM_BARS];
  logic [10:0] peak_row;

  // Peaks decay by one row per frame and are raised whenever a taller bar is stored
  always_comb begin
    peak_d = peak_q;
    if (fetch_start) begin
      for (int i = 0; i < NUM_BARS; i++)
        if (peak_q[i] != '0) peak_d[i] = peak_q[i] - 11'd1;
    end else if (state_q == STORE && h_new > peak_q[idx_q]) begin
      peak_d[idx_q] = h_new;
    end
    peak_row  = V_LIM - peak_q[s1_bar_q];
    peak_mark = s1_valid_q && (peak_q[s1_bar_q] != '0) &&
                ((s1_y_q == peak_row) || (s1_y_q == peak_row + 11'd1));
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BARS; i++) peak_q[i] <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end
`else
  assign peak_mark = 1'b0;
`endif

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wait_cnt_q   <= '0;
      sample_q     <= '0;
      data_req_q   <= 1'b0;
      wr_over_q    <= 1'b0;
      fetch_busy_q <= 1'b0;
      vs_q         <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) height_q[i] <= '0;
      s1_valid_q   <= 1'b0;
      s1_bar_q     <= '0;
      s1_y_q       <= '0;
      pixel_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_cnt_q   <= wait_cnt_d;
      sample_q     <= sample_d;
      data_req_q   <= data_req_d;
      wr_over_q    <= wr_over_d;
      fetch_busy_q <= fetch_busy_d;
      vs_q         <= vs_d;
      height_q     <= height_d;
      s1_valid_q   <= s1_valid_d;
      s1_bar_q     <= s1_bar_d;
      s1_y_q       <= s1_y_d;
      pixel_data_q <= pixel_data_d;
    end
  end

  assign data_req   = data_req_q;
  assign wr_over    = wr_over_q;
  assign fetch_busy = fetch_busy_q;
  assign pixel_data = pixel_data_q;

endmodule
